// File: rtl/ttl_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttl_sched_pkg
// Description : Shared FSM state encodings and a one-hot helper for the
//               ttl_74153 round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ttl_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // One-hot vector with bit idx set; callers truncate to their width
    function automatic logic [31:0] onehot_from_index(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttl_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : ttl_rr_picker
// Description : Combinational round-robin picker. Returns the first request
//               found scanning upward with wrap from (last+1), ignoring any
//               requester set in the exclude mask.
// Revision    : 1.0 - initial release
// ============================================================================
module ttl_rr_picker #(
    parameter int WIDTH_IN     = 4,
    parameter int WIDTH_SELECT = $clog2(WIDTH_IN)
) (
    input  logic [WIDTH_IN-1:0]     i_request,
    input  logic [WIDTH_SELECT-1:0] i_last,
    input  logic [WIDTH_IN-1:0]     i_exclude,
    output logic                    o_found,
    output logic [WIDTH_SELECT-1:0] o_index
);

    logic [WIDTH_SELECT-1:0] w_idx;

    // Scan from the farthest candidate down to last+1 so the nearest one wins;
    // WIDTH_IN is a power of two, so the index add wraps for free
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_idx   = '0;
        for (int k = WIDTH_IN; k >= 1; k--) begin
            w_idx = i_last + WIDTH_SELECT'(k);
            if (i_request[w_idx] && !i_exclude[w_idx]) begin
                o_found = 1'b1;
                o_index = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ttl_74153_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ttl_74153_scheduler
// Description : Round-robin scheduler sharing one dual 4-input mux among
//               WIDTH_IN requesters. Drives Select / Enable_bar and returns a
//               one-hot Grant, with minimum hold and optional maximum tenure.
//               Optional macro TTL_74153_SCHEDULER_BREAK_BEFORE_MAKE_EN
//               inserts a one-cycle GAP (mux disabled) between owners.
// Revision    : 1.0 - initial release
// ============================================================================
module ttl_74153_scheduler
    import ttl_sched_pkg::*;
#(
    parameter int BLOCKS       = 2,
    parameter int WIDTH_IN     = 4,
    parameter int WIDTH_SELECT = $clog2(WIDTH_IN),
    parameter int HOLD_CYCLES  = 2,
    parameter int MAX_CYCLES   = 8,
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic                    Clk,
    input  logic                    Clear,
    input  logic [WIDTH_IN-1:0]     Request,
    output logic [WIDTH_SELECT-1:0] Select,
    output logic [BLOCKS-1:0]       Enable_bar,
    output logic [WIDTH_IN-1:0]     Grant,
    output logic                    Busy
);

    // Counter saturates at the larger of the two tenure limits
    localparam int CNT_MAX = (MAX_CYCLES > HOLD_CYCLES) ? MAX_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]        c_HOLD      = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]        c_MAX       = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]        c_SAT       = CNT_W'(CNT_MAX);
    localparam logic [WIDTH_SELECT-1:0] c_LAST_INIT = WIDTH_SELECT'(WIDTH_IN - 1);

    state_t                  r_state;
    logic [WIDTH_SELECT-1:0] r_owner;
    logic [WIDTH_SELECT-1:0] r_last;
    logic [CNT_W-1:0]        r_count;
    logic [WIDTH_SELECT-1:0] r_select;
    logic [BLOCKS-1:0]       r_enable_bar;
    logic [WIDTH_IN-1:0]     r_grant;
    logic                    r_busy;

    logic [WIDTH_IN-1:0]     w_owner_oh;
    logic [WIDTH_IN-1:0]     w_pick_oh;
    logic [WIDTH_SELECT-1:0] w_pick_last;
    logic [WIDTH_IN-1:0]     w_pick_excl;
    logic                    w_found;
    logic [WIDTH_SELECT-1:0] w_pick;
    logic                    w_hold_met;
    logic                    w_max_hit;
    logic                    w_end;

    // While granting, the owner is the rotation origin and never re-picked
    assign w_owner_oh  = WIDTH_IN'(onehot_from_index(5'(r_owner)));
    assign w_pick_oh   = WIDTH_IN'(onehot_from_index(5'(w_pick)));
    assign w_pick_last = (r_state == GRANT) ? r_owner : r_last;
    assign w_pick_excl = (r_state == GRANT) ? w_owner_oh : '0;

    ttl_rr_picker #(
        .WIDTH_IN     (WIDTH_IN),
        .WIDTH_SELECT (WIDTH_SELECT)
    ) u_picker (
        .i_request (Request),
        .i_last    (w_pick_last),
        .i_exclude (w_pick_excl),
        .o_found   (w_found),
        .o_index   (w_pick)
    );

    // Tenure ends on release after the hold, or on timeout with a waiter
    assign w_hold_met = (r_count >= c_HOLD);
    assign w_max_hit  = (MAX_CYCLES != 0) && (r_count >= c_MAX) && w_found;
    assign w_end      = (!Request[r_owner] && w_hold_met) || w_max_hit;

    // Scheduler FSM with tenure counter and registered mux controls
    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last       <= c_LAST_INIT;
            r_count      <= '0;
            r_select     <= '0;
            r_enable_bar <= '1;
            r_grant      <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state      <= GRANT;
                        r_owner      <= w_pick;
                        r_count      <= CNT_W'(1);
                        r_select     <= w_pick;
                        r_grant      <= w_pick_oh;
                        r_enable_bar <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_end) begin
                        r_last <= r_owner;
`ifdef TTL_74153_SCHEDULER_BREAK_BEFORE_MAKE_EN
                        // Break before make: disable the mux for one cycle
                        r_state      <= GAP;
                        r_count      <= '0;
                        r_enable_bar <= '1;
                        r_grant      <= '0;
                        r_busy       <= 1'b1;
`else
                        if (w_found) begin
                            r_state      <= GRANT;
                            r_owner      <= w_pick;
                            r_count      <= CNT_W'(1);
                            r_select     <= w_pick;
                            r_grant      <= w_pick_oh;
                            r_enable_bar <= '0;
                            r_busy       <= 1'b1;
                        end else begin
                            r_state      <= IDLE;
                            r_count      <= '0;
                            r_select     <= '0;
                            r_enable_bar <= '1;
                            r_grant      <= '0;
                            r_busy       <= 1'b0;
                        end
`endif
                    end else if (r_count != c_SAT) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (w_found) begin
                        r_state      <= GRANT;
                        r_owner      <= w_pick;
                        r_count      <= CNT_W'(1);
                        r_select     <= w_pick;
                        r_grant      <= w_pick_oh;
                        r_enable_bar <= '0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state      <= IDLE;
                        r_count      <= '0;
                        r_select     <= '0;
                        r_enable_bar <= '1;
                        r_grant      <= '0;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_count      <= '0;
                    r_select     <= '0;
                    r_enable_bar <= '1;
                    r_grant      <= '0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Output drive: zero-delay builds skip the delayed assignment entirely
    generate
        if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
            assign Select     = r_select;
            assign Enable_bar = r_enable_bar;
            assign Grant      = r_grant;
            assign Busy       = r_busy;
        end else begin : g_dly
            assign #(DELAY_RISE, DELAY_FALL) Select     = r_select;
            assign #(DELAY_RISE, DELAY_FALL) Enable_bar = r_enable_bar;
            assign #(DELAY_RISE, DELAY_FALL) Grant      = r_grant;
            assign #(DELAY_RISE, DELAY_FALL) Busy       = r_busy;
        end
    endgenerate

endmodule
`default_nettype wire
